// File: rtl/mux_n_pipe.sv
// ---------------------------------------------------------------------------
// mux_n_pipe
//
// N-way, WIDTH-bit selector feeding a 2-entry output queue with a
// valid/ready handshake on both sides. The selected word (or a zero word
// flagged as an error when the select is out of range) is captured on push
// and presented from the queue head one cycle later.
//
// Optional feature (compile-time macro):
//   MUXN_ERR_CNT_EN  adds the err_count output, an 8-bit saturating count
//                    of pushes whose select was >= N. Cleared only by reset.
//
// Parameters:
//   N      number of data inputs (2..64)
//   WIDTH  data width in bits
//   SEL_W  select width, 2**SEL_W >= N
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   in_valid   in   producer offers {signal, data_in}
//   in_ready   out  queue has room (count < 2)
//   signal     in   select index
//   data_in    in   flat bus, input k = data_in[k*WIDTH +: WIDTH]
//   out_valid  out  head entry valid (count > 0)
//   out_ready  in   consumer takes the head entry this cycle
//   data_Out   out  head entry data, 0 when empty
//   sel_err    out  head entry was captured with signal >= N, 0 when empty
//   err_count  out  saturating out-of-range push count (MUXN_ERR_CNT_EN only)
// ---------------------------------------------------------------------------
module mux_n_pipe #(
    parameter int N     = 7,
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   signal,
    input  logic [N*WIDTH-1:0] data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   data_Out,
    output logic               sel_err
`ifdef MUXN_ERR_CNT_EN
    ,
    output logic [7:0]         err_count
`endif
);

    // Queue storage and bookkeeping
    logic [WIDTH-1:0] r_mem [0:1];
    logic [1:0]       r_err;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;

    // Handshake status depends only on the registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // The select is widened by one bit so that N == 2**SEL_W compares
    // correctly instead of wrapping to zero.
    assign w_sel_err = ({1'b0, signal} >= (SEL_W+1)'(N));

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if ({1'b0, signal} == (SEL_W+1)'(k)) begin
                w_sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_err    <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_sel_data;
                r_err[r_wr_ptr] <= w_sel_err;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero when empty so stale storage never leaks out.
    assign data_Out = out_valid ? r_mem[r_rd_ptr] : '0;
    assign sel_err  = out_valid ? r_err[r_rd_ptr] : 1'b0;

`ifdef MUXN_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_push && w_sel_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=7, WIDTH=32, SEL_W=3
    logic         a_reset = 1'b1;
    logic         a_in_valid = 1'b0;
    logic         a_in_ready;
    logic [2:0]   a_signal = '0;
    logic [223:0] a_data_in = '0;
    logic         a_out_valid;
    logic         a_out_ready = 1'b0;
    logic [31:0]  a_data_out;
    logic         a_sel_err;
    logic [7:0]   a_err_count;

    // DUT B: N=16, WIDTH=8, SEL_W=4
    logic         b_reset = 1'b1;
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [3:0]   b_signal = '0;
    logic [127:0] b_data_in = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [7:0]   b_data_out;
    logic         b_sel_err;
    logic [7:0]   b_err_count;

    mux_n_pipe #(.N(7), .WIDTH(32), .SEL_W(3)) u_dut_a (
        .clk       (clk),
        .reset     (a_reset),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .signal    (a_signal),
        .data_in   (a_data_in),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .data_Out  (a_data_out),
        .sel_err   (a_sel_err)
`ifdef MUXN_ERR_CNT_EN
        ,
        .err_count (a_err_count)
`endif
    );

    mux_n_pipe #(.N(16), .WIDTH(8), .SEL_W(4)) u_dut_b (
        .clk       (clk),
        .reset     (b_reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .signal    (b_signal),
        .data_in   (b_data_in),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .data_Out  (b_data_out),
        .sel_err   (b_sel_err)
`ifdef MUXN_ERR_CNT_EN
        ,
        .err_count (b_err_count)
`endif
    );

`ifndef MUXN_ERR_CNT_EN
    assign a_err_count = '0;
    assign b_err_count = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model for DUT A: a plain queue of {err, data} entries.
    typedef struct {
        bit          err;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   m_ecnt = 0;

    // Applies the current A inputs across one clock edge in both DUT and model.
    task automatic tick_a();
        bit   push, pop;
        int   s;
        ent_t e;
        push = a_in_valid && (q.size() < 2);
        pop  = (q.size() > 0) && a_out_ready;
        s    = int'(a_signal);
        e.err  = (s >= 7);
        e.data = (s < 7) ? a_data_in[s*32 +: 32] : 32'h0;
        @(posedge clk);
        #1;
        if (a_reset) begin
            q.delete();
            m_ecnt = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(e);
                if (e.err && m_ecnt < 255) m_ecnt++;
            end
        end
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(string tag);
        check({tag, "_valid"}, 32'(a_out_valid), 32'(q.size() > 0));
        check({tag, "_ready"}, 32'(a_in_ready), 32'(q.size() < 2));
        check({tag, "_data"}, a_data_out, (q.size() > 0) ? q[0].data : 32'h0);
        check({tag, "_err"}, 32'(a_sel_err), (q.size() > 0) ? 32'(q[0].err) : 32'h0);
`ifdef MUXN_ERR_CNT_EN
        check({tag, "_ecnt"}, 32'(a_err_count), 32'(m_ecnt));
`endif
    endtask

    typedef struct {
        bit          iv;
        int          sel;
        bit          ordy;
        bit          ev;
        logic [31:0] ed;
        bit          ee;
        bit          er;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int pushes;
        int cycles;

        // Directed table; data word k = k+1 except word 5 = DEADBEEF.
        //          iv sel ordy | valid data          err ready
        tbl[0]  = '{1, 5, 1,   1, 32'hDEAD_BEEF, 0, 1};
        tbl[1]  = '{0, 0, 1,   0, 32'h0,         0, 1};
        tbl[2]  = '{1, 0, 0,   1, 32'h1,         0, 1};
        tbl[3]  = '{1, 1, 0,   1, 32'h1,         0, 0};
        tbl[4]  = '{1, 2, 0,   1, 32'h1,         0, 0};
        tbl[5]  = '{0, 0, 1,   1, 32'h2,         0, 1};
        tbl[6]  = '{0, 0, 1,   0, 32'h0,         0, 1};
        tbl[7]  = '{1, 7, 1,   1, 32'h0,         1, 1};
        tbl[8]  = '{0, 0, 1,   0, 32'h0,         0, 1};
        tbl[9]  = '{1, 6, 0,   1, 32'h7,         0, 1};
        tbl[10] = '{1, 7, 1,   1, 32'h0,         1, 1};
        tbl[11] = '{0, 0, 1,   0, 32'h0,         0, 1};

        // Reset then idle three cycles
        tick_a();
        b_reset = 1'b0;
        a_reset = 1'b0;
        for (int i = 0; i < 3; i++) tick_a();
        check("rst_valid", 32'(a_out_valid), 32'h0);
        check("rst_ready", 32'(a_in_ready), 32'h1);
        check("rst_data", a_data_out, 32'h0);
        check("rst_err", 32'(a_sel_err), 32'h0);
`ifdef MUXN_ERR_CNT_EN
        check("rst_ecnt", 32'(a_err_count), 32'h0);
`endif

        for (int k = 0; k < 7; k++) a_data_in[k*32 +: 32] = 32'(k + 1);
        a_data_in[5*32 +: 32] = 32'hDEAD_BEEF;
        for (int i = 0; i < 12; i++) begin
            a_in_valid  = tbl[i].iv;
            a_signal    = 3'(tbl[i].sel);
            a_out_ready = tbl[i].ordy;
            tick_a();
            check($sformatf("tbl%0d_valid", i), 32'(a_out_valid), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_data", i), a_data_out, tbl[i].ed);
            check($sformatf("tbl%0d_err", i), 32'(a_sel_err), 32'(tbl[i].ee));
            check($sformatf("tbl%0d_ready", i), 32'(a_in_ready), 32'(tbl[i].er));
`ifdef MUXN_ERR_CNT_EN
            check($sformatf("tbl%0d_ecnt", i), 32'(a_err_count), 32'(m_ecnt));
`endif
        end

        // 300 out-of-range pushes with the consumer always ready
        a_in_valid  = 1'b1;
        a_signal    = 3'd7;
        a_out_ready = 1'b1;
        for (int i = 0; i < 300; i++) tick_a();
        check("oor_err", 32'(a_sel_err), 32'h1);
        check("oor_data", a_data_out, 32'h0);
`ifdef MUXN_ERR_CNT_EN
        check("oor_ecnt_sat", 32'(a_err_count), 32'd255);
`endif
        a_in_valid = 1'b0;
        tick_a();
        check_model("oor_drain");

        // Random streaming against the queue model
        pushes = 0;
        cycles = 0;
        while (pushes < 100 && cycles < 2000) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_signal    = 3'($urandom_range(0, 7));
            a_out_ready = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 7; k++) a_data_in[k*32 +: 32] = $urandom;
            if (a_in_valid && q.size() < 2) pushes++;
            tick_a();
            check_model($sformatf("rand%0d", cycles));
            cycles++;
        end
        check("rand_pushes", 32'(pushes), 32'd100);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick_a();
        tick_a();
        check_model("rand_drain");

        // Reset while full discards both entries and voids the handshake
        for (int k = 0; k < 7; k++) a_data_in[k*32 +: 32] = 32'(k + 1);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_signal    = 3'd0;
        tick_a();
        a_signal = 3'd1;
        tick_a();
        check("full_ready", 32'(a_in_ready), 32'h0);
        a_reset     = 1'b1;
        a_signal    = 3'd2;
        a_out_ready = 1'b1;
        tick_a();
        a_reset = 1'b0;
        check("midrst_valid", 32'(a_out_valid), 32'h0);
        check("midrst_ready", 32'(a_in_ready), 32'h1);
        a_signal    = 3'd3;
        a_out_ready = 1'b0;
        tick_a();
        check("midrst_data", a_data_out, 32'h4);
        check_model("midrst_push");
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick_a();
        check("midrst_empty", 32'(a_out_valid), 32'h0);

        // Same sequence on the N=16, WIDTH=8 instance, including select 15
        for (int k = 0; k < 16; k++) b_data_in[k*8 +: 8] = 8'(8'hA0 + k);
        b_in_valid = 1'b1;
        b_signal   = 4'd15;
        tick_b();
        check("b_sel15_data", 32'(b_data_out), 32'hAF);
        check("b_sel15_err", 32'(b_sel_err), 32'h0);
        b_signal = 4'd0;
        tick_b();
        check("b_full_ready", 32'(b_in_ready), 32'h0);
        b_reset    = 1'b1;
        b_signal   = 4'd3;
        b_out_ready = 1'b1;
        tick_b();
        b_reset = 1'b0;
        check("b_rst_valid", 32'(b_out_valid), 32'h0);
        check("b_rst_ready", 32'(b_in_ready), 32'h1);
        b_signal    = 4'd4;
        b_out_ready = 1'b0;
        tick_b();
        check("b_push_data", 32'(b_data_out), 32'hA4);
        check("b_push_valid", 32'(b_out_valid), 32'h1);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        tick_b();
        check("b_empty_valid", 32'(b_out_valid), 32'h0);
        check("b_empty_data", 32'(b_data_out), 32'h0);
`ifdef MUXN_ERR_CNT_EN
        check("b_ecnt", 32'(b_err_count), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
